// File: rtl/int_dispatch_queue_pkg.sv
// Shared integer dispatch-queue types and sizing constants used by dispatch and issue.
package int_dispatch_queue_pkg;

   localparam int unsigned INTDQ_DEPTH = 16;
   localparam int unsigned INTDQ_ENQ   = 4;
   localparam int unsigned INTDQ_DEQ   = 2;
   localparam int unsigned INTDQ_IDX_W = $clog2(INTDQ_DEPTH);

   typedef logic [INTDQ_IDX_W-1:0] dqIdx_t;

   typedef struct packed {
      logic [5:0] rob_idx;
      logic [5:0] pdst;
      logic [5:0] psrc1;
      logic [5:0] psrc2;
      logic [3:0] fu_op;
   } intDQEntry_t;

endpackage

// File: rtl/int_dispatch_queue_lead_one_count.sv
// lead_one_count: number of consecutive ones in i_vec starting at bit 0.
module int_dispatch_queue_lead_one_count #(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0]             i_vec,
   output logic [$clog2(WIDTH+1)-1:0]   o_cnt
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   always_comb begin : p_count
      logic w_run;
      w_run = 1'b1;
      o_cnt = '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
         w_run = w_run & i_vec[k];
         if (w_run) o_cnt = o_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/int_dispatch_queue.sv
// In-order multi-lane integer dispatch queue: circular buffer with prefix-accept dequeue,
// full flush on squash, and occupancy / almost-full outputs for dispatch backpressure.
module int_dispatch_queue
   import int_dispatch_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = INTDQ_DEPTH,
   parameter int unsigned ENQ_WIDTH    = INTDQ_ENQ,
   parameter int unsigned DEQ_WIDTH    = INTDQ_DEQ,
   parameter int unsigned AFULL_THRESH = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_squash_vld,
   input  logic [ENQ_WIDTH-1:0]          i_enq_vld,
   input  intDQEntry_t [ENQ_WIDTH-1:0]   i_enq_info,
   output logic                          o_can_enq,
   output logic [DEQ_WIDTH-1:0]          o_deq_vld,
   output intDQEntry_t [DEQ_WIDTH-1:0]   o_deq_info,
   input  logic [DEQ_WIDTH-1:0]          i_deq_rdy,
   output logic [$clog2(DEPTH):0]        o_count,
   output logic                          o_almost_full
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = IDX_W + 1;
   localparam int unsigned ENQ_CW = $clog2(ENQ_WIDTH + 1);
   localparam int unsigned DEQ_CW = $clog2(DEQ_WIDTH + 1);

   logic [IDX_W-1:0]  r_head;
   logic [IDX_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   intDQEntry_t       r_mem [DEPTH];

   logic [ENQ_CW-1:0]    w_n_enq;
   logic [DEQ_CW-1:0]    w_n_deq;
   logic                 w_can_enq;
   logic                 w_enq_fire;
   logic [CNT_W-1:0]     w_enq_add;
   logic [DEQ_WIDTH-1:0] w_deq_vld;
   logic [IDX_W-1:0]     w_wr_idx [ENQ_WIDTH];
   logic [IDX_W-1:0]     w_rd_idx [DEQ_WIDTH];

   // Conservative: only registered count, so no comb path from i_deq_rdy to o_can_enq.
   assign w_can_enq  = (CNT_W'(DEPTH) - r_count) >= CNT_W'(ENQ_WIDTH);
   assign w_enq_fire = w_can_enq & ~i_squash_vld;
   assign w_enq_add  = w_enq_fire ? CNT_W'(w_n_enq) : '0;

   always_comb begin
      w_n_enq = '0;
      for (int unsigned j = 0; j < ENQ_WIDTH; j++) begin
         w_n_enq     = w_n_enq + ENQ_CW'(i_enq_vld[j]);
         w_wr_idx[j] = r_tail + IDX_W'(j);
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < DEQ_WIDTH; k++) begin
         w_deq_vld[k]  = CNT_W'(k) < r_count;
         w_rd_idx[k]   = r_head + IDX_W'(k);
         o_deq_info[k] = r_mem[w_rd_idx[k]];
      end
   end

   // Only an unbroken run of accepts from lane 0 retires entries, keeping order.
   int_dispatch_queue_lead_one_count #(
      .WIDTH (DEQ_WIDTH)
   ) u_deq_cnt (
      .i_vec (w_deq_vld & i_deq_rdy),
      .o_cnt (w_n_deq)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_squash_vld) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + IDX_W'(w_n_deq);
         if (w_enq_fire) r_tail <= r_tail + IDX_W'(w_n_enq);
         r_count <= r_count + w_enq_add - CNT_W'(w_n_deq);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < ENQ_WIDTH; j++) begin
         if (w_enq_fire && i_enq_vld[j]) r_mem[w_wr_idx[j]] <= i_enq_info[j];
      end
   end

   assign o_can_enq     = w_can_enq;
   assign o_deq_vld     = w_deq_vld;
   assign o_count       = r_count;
   assign o_almost_full = r_count >= CNT_W'(AFULL_THRESH);

   a_enq_contig : assert property (@(posedge clk) disable iff (!rst)
      ((i_enq_vld & (i_enq_vld + ENQ_WIDTH'(1))) == '0))
      else $error("i_enq_vld lanes not contiguous from lane 0: %b", i_enq_vld);

   a_enq_dropped : assert property (@(posedge clk) disable iff (!rst)
      ((|i_enq_vld) && !i_squash_vld) |-> w_can_enq)
      else $error("enqueue attempted while o_can_enq=0");

endmodule
